mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mdu_pkg.sv | 14 +
 rtl/mul_div_unit.sv | 96 +++++++++
 tb/tb_mul_div_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings and FSM states for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;
endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed/unsigned multiply and restoring divide into HI/LO
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int CW = $clog2(XLEN);
  mdu_state_e state, state_n;
  mdu_op_e op_r;
  logic sa, sb, a_neg, b_neg, accept, is_div, ge;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] md, ma, mb, q, r;
  logic [XLEN:0] msum, t, diff;
  logic [2*XLEN:0] w, sh, w_step;
  logic [2*XLEN-1:0] p, res;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = flush ? ST_IDLE :
              state == ST_IDLE ? (start ? ST_RUN : ST_IDLE) :
              state == ST_RUN ? (cnt == '0 ? ST_FIX : ST_RUN) : ST_IDLE;
  end
  always_comb begin
    busy = state != ST_IDLE;
  end
  always_comb begin
    is_div = op_r == OP_DIV || op_r == OP_DIVU;
    a_neg = ~op[0] & a[XLEN-1];
    b_neg = ~op[0] & b[XLEN-1];
    ma = a_neg ? -a : a;
    mb = b_neg ? -b : b;
    accept = state == ST_IDLE && start && !flush;
    msum = w[2*XLEN:XLEN] + (w[0] ? {1'b0, md} : '0);
    sh = {w[2*XLEN-1:0], 1'b0};
    t = sh[2*XLEN:XLEN];
    ge = t >= {1'b0, md};
    diff = t - {1'b0, md};
    w_step = is_div ? {ge ? diff : t, sh[XLEN-1:1], ge} : {1'b0, msum, w[XLEN-1:1]};
    p = w[2*XLEN-1:0];
    q = w[XLEN-1:0];
    r = w[2*XLEN-1:XLEN];
    res = !is_div ? ((sa ^ sb) ? -p : p) :
          md == '0 ? {r, {XLEN{1'b1}}} :
          {sa ? -r : r, (sa ^ sb) ? -q : q};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r <= OP_MULT;
      sa <= 1'b0;
      sb <= 1'b0;
      md <= '0;
      w <= '0;
      cnt <= '0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= state == ST_FIX && !flush;
      if (accept) begin
        op_r <= mdu_op_e'(op);
        sa <= a_neg;
        sb <= b_neg;
        md <= op[1] ? mb : ma;
        w <= {{(XLEN+1){1'b0}}, op[1] ? ma : mb};
        cnt <= CW'(XLEN-1);
      end else if (state == ST_RUN) begin
        w <= w_step;
        cnt <= cnt - CW'(1);
      end
      if (state == ST_FIX && !flush) begin
        hi <= res[2*XLEN-1:XLEN];
        lo <= res[XLEN-1:0];
      end else if (!busy) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import mdu_pkg::*;
  logic clk = 0, reset = 1, start = 0, flush = 0, wr_hi = 0, wr_lo = 0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = 0, b = 0, wdata = 0;
  logic busy, done;
  logic [31:0] hi, lo;
  logic seen;
  int checks = 0, errors = 0, n;
  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1;
    @(posedge clk);
    #1 start = 0; wr_hi = 0; wr_lo = 0;
  endtask
  task automatic wait_done(output int c);
    c = 0;
    do begin
      @(posedge clk);
      #1 c++;
    end while (!done && c < 100);
  endtask
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    go(o, x, y);
    wait_done(n);
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
  endtask
  initial begin
    #2 reset = 0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(negedge clk) reset = 1;
    @(negedge clk);
    run("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    @(posedge clk);
    #1;
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    run("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("div_ovf_b2b", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
    run("div_negdiv", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    wdata = 32'hAB; wr_hi = 1; wr_lo = 1;
    go(OP_MULT, 32'd100, 32'hFFFFFF9C);
    chk("coinc_hi", 64'(hi), 64'hAB);
    chk("coinc_lo", 64'(lo), 64'hAB);
    chk("coinc_busy", 64'(busy), 64'd1);
    wait_done(n);
    chk("coinc_latency", 64'(n), 64'd33);
    chk("coinc_res_hi", 64'(hi), 64'hFFFFFFFF);
    chk("coinc_res_lo", 64'(lo), 64'hFFFFD8F0);
    wr_hi = 1; wdata = 32'h11;
    @(posedge clk);
    #1 wr_hi = 0; wr_lo = 1; wdata = 32'h22;
    go(OP_MULTU, 32'd5, 32'd6);
    repeat (10) @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    chk("flush_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 seen |= done;
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    chk("flush_hi", 64'(hi), 64'h11);
    chk("flush_lo", 64'(lo), 64'h22);
    run("restart", OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30);
    go(OP_DIV, 32'd1000, 32'd7);
    repeat (4) @(posedge clk);
    #1 wr_lo = 1; wdata = 32'hDEAD;
    @(posedge clk);
    #1 wr_lo = 0;
    chk("busy_wr_lo", 64'(lo), 64'd30);
    chk("busy_mid", 64'(busy), 64'd1);
    repeat (10) @(posedge clk);
    #3 reset = 0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clk) reset = 1;
    @(negedge clk);
    run("post_rst_divu", OP_DIVU, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
